// File: rtl/compute_cluster_combiner.sv
// compute_cluster_combiner: merges NUM_UNITS compute-unit output bundles into registered chip-level outputs
//   clk, rst_n           clock, asynchronous active-low reset
//   ena                  block enable; low freezes every register and forces cfg_ready low
//   unit_uo/uio_out/oe   per-unit buses, unit k at bits [8k+7:8k]
//   cfg_valid/cfg_data   config request {mask, sel, mode}, mode in the LSBs
//   cfg_ready            config accept-ready
//   uo_out/uio_out/oe    combined outputs, one cycle after the unit inputs
//   active_unit          unit owning the outputs in select / round-robin modes
//   oe_conflict          sticky flag: two live units drove the same uio_oe bit (modes 0/1)
module compute_cluster_combiner #(
   parameter int NUM_UNITS = 4,
   parameter int DWELL = 16,
   localparam int SEL_W = (NUM_UNITS > 2) ? $clog2(NUM_UNITS) : 1,
   localparam int CFG_W = 2 + SEL_W + NUM_UNITS
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ena,
   input  logic [8*NUM_UNITS-1:0] unit_uo,
   input  logic [8*NUM_UNITS-1:0] unit_uio_out,
   input  logic [8*NUM_UNITS-1:0] unit_uio_oe,
   input  logic                   cfg_valid,
   input  logic [CFG_W-1:0]       cfg_data,
   output logic                   cfg_ready,
   output logic [7:0]             uo_out,
   output logic [7:0]             uio_out,
   output logic [7:0]             uio_oe,
   output logic [SEL_W-1:0]       active_unit,
   output logic                   oe_conflict
);
   typedef enum logic {READY, SETTLE} state_t;
   state_t state, state_nx;
   logic [1:0] mode;
   logic [SEL_W-1:0] sel, rr_ptr, rr_nx, rr_hi, rr_lo, first_live, pick, active_nx;
   logic rr_hi_ok, accept, wrap, conflict;
   logic [NUM_UNITS-1:0] mask, cfg_mask;
   logic [7:0] dwell_cnt;
   logic [7:0] x_uo, or_uo, or_uio, or_oe, dup, p_uo, p_uio, p_oe, uo_nx, uio_nx, oe_nx;

   assign cfg_mask = cfg_data[2+SEL_W +: NUM_UNITS];

   always_comb begin
      state_nx = state;
      cfg_ready = 1'b0;
      if (ena) begin
         cfg_ready = (state == READY);
         state_nx = (state == SETTLE) ? READY : (cfg_valid ? SETTLE : READY);
      end
   end

   assign accept = cfg_valid && cfg_ready;
   assign pick = (mode == 2'd2) ? sel : rr_ptr;

   // dup collects bits already seen in an earlier live unit, i.e. enable collisions
   always_comb begin
      x_uo = '0;
      or_uo = '0;
      or_uio = '0;
      or_oe = '0;
      dup = '0;
      p_uo = '0;
      p_uio = '0;
      p_oe = '0;
      for (int k = 0; k < NUM_UNITS; k++) begin
         if (mask[k]) begin
            x_uo = x_uo ^ unit_uo[8*k +: 8];
            or_uo = or_uo | unit_uo[8*k +: 8];
            or_uio = or_uio | unit_uio_out[8*k +: 8];
            dup = dup | (or_oe & unit_uio_oe[8*k +: 8]);
            or_oe = or_oe | unit_uio_oe[8*k +: 8];
         end
         if (mask[k] && pick == SEL_W'(k)) begin
            p_uo = unit_uo[8*k +: 8];
            p_uio = unit_uio_out[8*k +: 8];
            p_oe = unit_uio_oe[8*k +: 8];
         end
      end
   end

   // Descending scan: the last hit is the lowest index. rr_hi is the lowest live unit
   // above rr_ptr; failing that the search wraps to the lowest live unit overall.
   always_comb begin
      first_live = '0;
      rr_hi = rr_ptr;
      rr_lo = rr_ptr;
      rr_hi_ok = 1'b0;
      for (int k = NUM_UNITS - 1; k >= 0; k--) begin
         if (cfg_mask[k]) first_live = SEL_W'(k);
         if (mask[k]) begin
            rr_lo = SEL_W'(k);
            if (SEL_W'(k) > rr_ptr) begin
               rr_hi = SEL_W'(k);
               rr_hi_ok = 1'b1;
            end
         end
      end
   end

   assign rr_nx = rr_hi_ok ? rr_hi : rr_lo;
   assign uo_nx = mode[1] ? p_uo : (mode[0] ? or_uo : x_uo);
   assign uio_nx = mode[1] ? p_uio : or_uio;
   assign oe_nx = mode[1] ? p_oe : or_oe;
   assign active_nx = mode[1] ? pick : '0;
   assign conflict = !mode[1] && (dup != 8'd0);
   assign wrap = (mode == 2'd3) && (dwell_cnt == 8'(DWELL - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= READY;
      else state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         uo_out <= '0;
         uio_out <= '0;
         uio_oe <= '0;
         active_unit <= '0;
         oe_conflict <= 1'b0;
         mode <= 2'd0;
         sel <= '0;
         mask <= '1;
         rr_ptr <= '0;
         dwell_cnt <= '0;
      end else if (ena) begin
         uo_out <= uo_nx;
         uio_out <= uio_nx;
         uio_oe <= oe_nx;
         active_unit <= active_nx;
         // an accept overrides both a same-cycle conflict and a same-cycle rotation step
         if (accept) begin
            mode <= cfg_data[1:0];
            sel <= cfg_data[2 +: SEL_W];
            mask <= cfg_mask;
            oe_conflict <= 1'b0;
            dwell_cnt <= '0;
            rr_ptr <= first_live;
         end else begin
            if (conflict) oe_conflict <= 1'b1;
            if (wrap) begin
               dwell_cnt <= '0;
               rr_ptr <= rr_nx;
            end else if (mode == 2'd3) begin
               dwell_cnt <= dwell_cnt + 8'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_compute_cluster_combiner.sv
// tb_compute_cluster_combiner: self-checking bench for compute_cluster_combiner (NUM_UNITS=4, DWELL=4)
//   a cycle-level reference model is compared against the DUT on every enabled negedge,
//   a table of combine vectors is checked against hand-computed results,
//   and directed sequences cover handshake, round-robin, ena freeze and async reset.
module tb_compute_cluster_combiner;
   localparam int N = 4;
   localparam int DW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ena = 1'b1;
   logic [31:0] u_uo = '0, u_uio = '0, u_oe = '0;
   logic cfg_valid = 1'b0;
   logic [7:0] cfg_data = '0;
   logic cfg_ready, oe_conflict;
   logic [7:0] uo_out, uio_out, uio_oe;
   logic [1:0] active_unit;

   compute_cluster_combiner #(.NUM_UNITS(N), .DWELL(DW)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .unit_uo(u_uo), .unit_uio_out(u_uio), .unit_uio_oe(u_oe),
      .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
      .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe),
      .active_unit(active_unit), .oe_conflict(oe_conflict)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // ---------------- reference model ----------------
   int m_mode = 0, m_sel = 0, m_mask = 15, m_rr = 0, m_dw = 0, cnt;
   bit m_settle = 0, e_conf = 0, cnow, acc;
   int e_act = 0;
   logic [7:0] e_uo = '0, e_uio = '0, e_oe = '0, mx, mo1, mo2, mo3;

   function automatic logic [7:0] byt(input logic [31:0] v, input int k);
      return v[8*k +: 8];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = 0; m_sel = 0; m_mask = 15; m_rr = 0; m_dw = 0; m_settle = 0;
         e_uo = 0; e_uio = 0; e_oe = 0; e_act = 0; e_conf = 0;
      end else if (ena) begin
         acc = cfg_valid && !m_settle;
         mx = 0; mo1 = 0; mo2 = 0; mo3 = 0;
         for (int k = 0; k < N; k++)
            if (m_mask[k]) begin
               mx ^= byt(u_uo, k); mo1 |= byt(u_uo, k); mo2 |= byt(u_uio, k); mo3 |= byt(u_oe, k);
            end
         cnow = 0;
         for (int b = 0; b < 8; b++) begin
            cnt = 0;
            for (int k = 0; k < N; k++) if (m_mask[k] && u_oe[8*k+b]) cnt++;
            if (cnt >= 2) cnow = 1;
         end
         case (m_mode)
            0: begin e_uo = mx; e_uio = mo2; e_oe = mo3; e_act = 0; end
            1: begin e_uo = mo1; e_uio = mo2; e_oe = mo3; e_act = 0; end
            2: begin
               e_act = m_sel;
               if (m_sel < N && m_mask[m_sel]) begin
                  e_uo = byt(u_uo, m_sel); e_uio = byt(u_uio, m_sel); e_oe = byt(u_oe, m_sel);
               end else begin
                  e_uo = 0; e_uio = 0; e_oe = 0;
               end
            end
            default: begin
               e_act = m_rr;
               if (m_mask != 0) begin
                  e_uo = byt(u_uo, m_rr); e_uio = byt(u_uio, m_rr); e_oe = byt(u_oe, m_rr);
               end else begin
                  e_uo = 0; e_uio = 0; e_oe = 0;
               end
            end
         endcase
         if (acc) begin
            m_mode = int'(cfg_data[1:0]);
            m_sel = int'(cfg_data[3:2]);
            m_mask = int'(cfg_data[7:4]);
            e_conf = 0;
            m_dw = 0;
            m_rr = 0;
            while (m_rr < N && !m_mask[m_rr]) m_rr++;
            if (m_rr == N) m_rr = 0;
            m_settle = 1;
         end else begin
            m_settle = 0;
            if (cnow && m_mode < 2) e_conf = 1;
            if (m_mode == 3) begin
               m_dw++;
               if (m_dw == DW) begin
                  m_dw = 0;
                  if (m_mask != 0) do m_rr = (m_rr + 1) % N; while (!m_mask[m_rr]);
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("model uo_out", 32'(uo_out), 32'(e_uo));
         chk("model uio_out", 32'(uio_out), 32'(e_uio));
         chk("model uio_oe", 32'(uio_oe), 32'(e_oe));
         chk("model active_unit", 32'(active_unit), 32'(e_act));
         chk("model oe_conflict", 32'(oe_conflict), 32'(e_conf));
         chk("model cfg_ready", 32'(cfg_ready), 32'(ena && !m_settle));
      end
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0] cfg;
      logic [31:0] uo, uio, oe;
      logic [7:0] xuo, xuio, xoe;
      logic xconf;
   } vec_t;
   vec_t tv [7];

   task automatic do_cfg(input logic [7:0] d);
      cfg_valid = 1'b1;
      cfg_data = d;
      step();
      cfg_valid = 1'b0;
      step();
   endtask

   int rr_exp [4] = '{0, 1, 3, 0};
   logic [7:0] rr_uo [4] = '{8'h01, 8'h02, 8'h08, 8'h01};
   int rs_exp [4] = '{1, 1, 3, 3};

   initial begin
      tv[0] = '{8'hF0, 32'h0F3355FF, 32'h80402010, 32'h00000000, 8'h96, 8'hF0, 8'h00, 1'b0};
      tv[1] = '{8'h50, 32'h0F3355FF, 32'h80402010, 32'h01020408, 8'hCC, 8'h50, 8'h0A, 1'b0};
      tv[2] = '{8'h61, 32'h0F3355FF, 32'h80402010, 32'h01020408, 8'h77, 8'h60, 8'h06, 1'b0};
      tv[3] = '{8'hFE, 32'h0F3355FF, 32'h80402010, 32'h01020408, 8'h0F, 8'h80, 8'h01, 1'b0};
      tv[4] = '{8'hD6, 32'h0F3355FF, 32'h80402010, 32'h01020408, 8'h00, 8'h00, 8'h00, 1'b0};
      tv[5] = '{8'h00, 32'h0F3355FF, 32'h80402010, 32'h01020408, 8'h00, 8'h00, 8'h00, 1'b0};
      tv[6] = '{8'h91, 32'h0F3355FF, 32'h80402010, 32'h11000010, 8'hFF, 8'h90, 8'h11, 1'b1};

      // reset defaults
      u_uo = 32'h08040201;
      #3;
      chk("reset uo_out", 32'(uo_out), 0);
      chk("reset cfg_ready", 32'(cfg_ready), 1);
      chk("reset active_unit", 32'(active_unit), 0);
      step();
      rst_n = 1'b1;
      step();
      chk("post-reset xor uo_out", 32'(uo_out), 32'h0F);
      chk("post-reset cfg_ready", 32'(cfg_ready), 1);
      chk("post-reset oe_conflict", 32'(oe_conflict), 0);

      // mode 0 conflict, sticky, cleared by accept
      u_oe = 32'h00010001;
      step();
      chk("conflict uio_oe", 32'(uio_oe), 32'h01);
      chk("conflict set", 32'(oe_conflict), 1);
      u_oe = '0;
      step();
      chk("conflict sticky", 32'(oe_conflict), 1);
      cfg_valid = 1'b1;
      cfg_data = 8'hF0;
      step();
      chk("conflict cleared on accept", 32'(oe_conflict), 0);
      cfg_valid = 1'b0;
      step();

      // handshake timing and select mode
      cfg_valid = 1'b1;
      cfg_data = 8'h36;
      step();
      chk("settle cfg_ready low", 32'(cfg_ready), 0);
      cfg_valid = 1'b0;
      step();
      chk("ready again", 32'(cfg_ready), 1);
      chk("select sel1 uo_out", 32'(uo_out), 32'h02);
      chk("select sel1 active", 32'(active_unit), 1);
      do_cfg(8'h3A);
      chk("select masked uo_out", 32'(uo_out), 0);
      chk("select masked active", 32'(active_unit), 2);

      // table of combine vectors
      for (int i = 0; i < 7; i++) begin
         u_uo = tv[i].uo;
         u_uio = tv[i].uio;
         u_oe = tv[i].oe;
         do_cfg(tv[i].cfg);
         chk($sformatf("vec%0d uo_out", i), 32'(uo_out), 32'(tv[i].xuo));
         chk($sformatf("vec%0d uio_out", i), 32'(uio_out), 32'(tv[i].xuio));
         chk($sformatf("vec%0d uio_oe", i), 32'(uio_oe), 32'(tv[i].xoe));
         chk($sformatf("vec%0d oe_conflict", i), 32'(oe_conflict), 32'(tv[i].xconf));
      end

      // round-robin over mask 0xB
      u_uo = 32'h08040201;
      u_uio = '0;
      u_oe = '0;
      cfg_valid = 1'b1;
      cfg_data = 8'hB3;
      step();
      cfg_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step();
         chk($sformatf("rr cycle%0d active", i), 32'(active_unit), 32'(rr_exp[i/4]));
         chk($sformatf("rr cycle%0d uo_out", i), 32'(uo_out), 32'(rr_uo[i/4]));
      end
      step();
      step();

      // ena freeze mid-dwell
      ena = 1'b0;
      cfg_valid = 1'b1;
      cfg_data = 8'hF0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("freeze active", 32'(active_unit), 1);
         chk("freeze uo_out", 32'(uo_out), 32'h02);
         chk("freeze cfg_ready", 32'(cfg_ready), 0);
      end
      cfg_valid = 1'b0;
      ena = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("resume cycle%0d active", i), 32'(active_unit), 32'(rs_exp[i]));
      end

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         u_uo = $urandom;
         u_uio = $urandom;
         u_oe = $urandom & $urandom & $urandom;
         ena = ($urandom_range(0, 9) != 0);
         cfg_valid = ($urandom_range(0, 5) == 0);
         cfg_data = 8'($urandom);
         step();
      end
      ena = 1'b1;
      cfg_valid = 1'b0;
      step();
      step();

      // async reset during SETTLE
      cfg_valid = 1'b1;
      cfg_data = 8'hF1;
      step();
      #1 rst_n = 1'b0;
      cfg_valid = 1'b0;
      #1;
      chk("async reset uo_out", 32'(uo_out), 0);
      chk("async reset uio_oe", 32'(uio_oe), 0);
      chk("async reset active", 32'(active_unit), 0);
      chk("async reset cfg_ready", 32'(cfg_ready), 1);
      #2 rst_n = 1'b1;
      u_uo = 32'h00000503;
      u_uio = '0;
      u_oe = '0;
      step();
      chk("after reset mode is xor", 32'(uo_out), 32'h06);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
